// File: rtl/udp_rx_fcs_chk.sv
// GMII receive frame checker: strips preamble/SFD, forwards frame bytes with the FCS withheld
// by a 4-byte delay line, checks CRC-32 and length, and keeps saturating good/bad counters.
module udp_rx_fcs_chk #(
  parameter int unsigned MIN_FRAME = 64,
  parameter int unsigned MAX_FRAME = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  frm_data,
  output logic        frm_data_vld,
  output logic        frm_sof,
  output logic        frm_done,
  output logic        frm_good,
  output logic        frm_crc_err,
  output logic        frm_len_err,
  output logic [15:0] frm_len,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StPreamble = 2'd1;
  localparam logic [1:0] StData     = 2'd2;
  localparam logic [1:0] StDrop     = 2'd3;

  localparam logic [15:0] MinLen  = 16'(MIN_FRAME);
  localparam logic [15:0] MaxLen  = 16'(MAX_FRAME);
  localparam logic [31:0] CrcPoly = 32'hEDB88320;
  localparam logic [31:0] CrcRes  = 32'hDEBB20E3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] dly_q, dly_d;
  logic [7:0]  frm_data_q, frm_data_d;
  logic        frm_data_vld_q, frm_data_vld_d;
  logic        frm_sof_q, frm_sof_d;
  logic        frm_done_q, frm_done_d;
  logic        frm_good_q, frm_good_d;
  logic        frm_crc_err_q, frm_crc_err_d;
  logic        frm_len_err_q, frm_len_err_d;
  logic [15:0] frm_len_q, frm_len_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;
  logic        crc_err, len_err;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  assign crc_err = (crc_q != CrcRes);
  assign len_err = (cnt_q < MinLen) || (cnt_q > MaxLen);

  always_comb begin
    state_d        = state_q;
    pre_cnt_d      = pre_cnt_q;
    crc_d          = crc_q;
    cnt_d          = cnt_q;
    dly_d          = dly_q;
    frm_data_d     = frm_data_q;
    frm_data_vld_d = 1'b0;
    frm_sof_d      = 1'b0;
    frm_done_d     = 1'b0;
    frm_good_d     = frm_good_q;
    frm_crc_err_d  = frm_crc_err_q;
    frm_len_err_d  = frm_len_err_q;
    frm_len_d      = frm_len_q;
    good_cnt_d     = good_cnt_q;
    bad_cnt_d      = bad_cnt_q;

    case (state_q)
      StIdle: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == 8'h55) begin
            state_d   = StPreamble;
            pre_cnt_d = 3'd1;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StPreamble: begin
        if (!gmii_rx_dv) begin
          state_d = StIdle;
        end else if (gmii_rxd == 8'hD5) begin
          state_d = StData;
          crc_d   = 32'hFFFFFFFF;
          cnt_d   = 16'd0;
        end else if (gmii_rxd == 8'h55 && pre_cnt_q != 3'd7) begin
          pre_cnt_d = pre_cnt_q + 3'd1;
        end else begin
          state_d = StDrop;
        end
      end
      StData: begin
        if (gmii_rx_dv) begin
          dly_d = {dly_q[23:0], gmii_rxd};
          crc_d = crc_byte(crc_q, gmii_rxd);
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          // Oldest delay-line byte leaves once four bytes are held; cap at MAX_FRAME-4 bytes.
          if (cnt_q >= 16'd4 && cnt_q < MaxLen) begin
            frm_data_d     = dly_q[31:24];
            frm_data_vld_d = 1'b1;
            frm_sof_d      = (cnt_q == 16'd4);
          end
        end else begin
          state_d       = StIdle;
          frm_done_d    = 1'b1;
          frm_len_d     = cnt_q;
          frm_crc_err_d = crc_err;
          frm_len_err_d = len_err;
          frm_good_d    = ~crc_err & ~len_err;
          if (~crc_err & ~len_err) begin
            if (good_cnt_q != 16'hFFFF) good_cnt_d = good_cnt_q + 16'd1;
          end else begin
            if (bad_cnt_q != 16'hFFFF) bad_cnt_d = bad_cnt_q + 16'd1;
          end
        end
      end
      StDrop: begin
        if (!gmii_rx_dv) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      pre_cnt_q      <= 3'd0;
      crc_q          <= 32'd0;
      cnt_q          <= 16'd0;
      dly_q          <= 32'd0;
      frm_data_q     <= 8'd0;
      frm_data_vld_q <= 1'b0;
      frm_sof_q      <= 1'b0;
      frm_done_q     <= 1'b0;
      frm_good_q     <= 1'b0;
      frm_crc_err_q  <= 1'b0;
      frm_len_err_q  <= 1'b0;
      frm_len_q      <= 16'd0;
      good_cnt_q     <= 16'd0;
      bad_cnt_q      <= 16'd0;
    end else begin
      state_q        <= state_d;
      pre_cnt_q      <= pre_cnt_d;
      crc_q          <= crc_d;
      cnt_q          <= cnt_d;
      dly_q          <= dly_d;
      frm_data_q     <= frm_data_d;
      frm_data_vld_q <= frm_data_vld_d;
      frm_sof_q      <= frm_sof_d;
      frm_done_q     <= frm_done_d;
      frm_good_q     <= frm_good_d;
      frm_crc_err_q  <= frm_crc_err_d;
      frm_len_err_q  <= frm_len_err_d;
      frm_len_q      <= frm_len_d;
      good_cnt_q     <= good_cnt_d;
      bad_cnt_q      <= bad_cnt_d;
    end
  end

  assign frm_data     = frm_data_q;
  assign frm_data_vld = frm_data_vld_q;
  assign frm_sof      = frm_sof_q;
  assign frm_done     = frm_done_q;
  assign frm_good     = frm_good_q;
  assign frm_crc_err  = frm_crc_err_q;
  assign frm_len_err  = frm_len_err_q;
  assign frm_len      = frm_len_q;
  assign good_cnt     = good_cnt_q;
  assign bad_cnt      = bad_cnt_q;

endmodule

// File: tb/tb_udp_rx_fcs_chk.sv
// Randomized bench for udp_rx_fcs_chk: builds frames with a proper FCS, optionally corrupts
// them, and checks forwarded bytes and end-of-frame status against a frame-level model.
module tb_udp_rx_fcs_chk;

  localparam int MinF = 64;
  localparam int MaxF = 1518;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic [7:0]  frm_data;
  logic        frm_data_vld, frm_sof, frm_done, frm_good, frm_crc_err, frm_len_err;
  logic [15:0] frm_len, good_cnt, bad_cnt;

  udp_rx_fcs_chk #(.MIN_FRAME(MinF), .MAX_FRAME(MaxF)) dut (
    .clk         (clk),
    .rst         (rst),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rxd    (gmii_rxd),
    .frm_data    (frm_data),
    .frm_data_vld(frm_data_vld),
    .frm_sof     (frm_sof),
    .frm_done    (frm_done),
    .frm_good    (frm_good),
    .frm_crc_err (frm_crc_err),
    .frm_len_err (frm_len_err),
    .frm_len     (frm_len),
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_good = 0;
  int exp_bad  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Output monitor, sampled on the falling edge.
  byte unsigned got_q[$];
  byte unsigned frm_q[$];
  int          sof_cnt = 0, sof_bad = 0, done_cnt = 0;
  logic [15:0] last_len;
  logic        last_good, last_crc, last_lenerr;

  always @(negedge clk) begin
    if (frm_data_vld) begin
      if (frm_sof) begin
        sof_cnt++;
        if (got_q.size() != 0) sof_bad++;
      end
      got_q.push_back(frm_data);
    end else if (frm_sof) begin
      sof_bad++;
    end
    if (frm_done) begin
      done_cnt++;
      last_len    = frm_len;
      last_good   = frm_good;
      last_crc    = frm_crc_err;
      last_lenerr = frm_len_err;
    end
  end

  task automatic clear_mon();
    got_q.delete();
    sof_cnt  = 0;
    sof_bad  = 0;
    done_cnt = 0;
  endtask

  task automatic drive(input bit v, input logic [7:0] b);
    gmii_rx_dv = v;
    gmii_rxd   = b;
    @(posedge clk);
    #1;
  endtask

  // Bit-serial CRC-32 (reflected) over a byte queue.
  function automatic logic [31:0] crc32(input byte unsigned d[$]);
    logic [31:0] c;
    logic [7:0]  v;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      v = d[i];
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ v[b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  // Build an n-byte frame (n >= 5) whose last four bytes are the FCS; optionally flip a data bit.
  task automatic build_frame(input int n, input bit corrupt);
    logic [31:0] fcs;
    int          idx;
    frm_q.delete();
    for (int i = 0; i < n - 4; i++) frm_q.push_back(byte'($urandom_range(0, 255)));
    fcs = ~crc32(frm_q);
    for (int i = 0; i < 4; i++) frm_q.push_back(byte'(fcs >> (8 * i)));
    if (corrupt) begin
      idx = $urandom_range(0, n - 5);
      frm_q[idx] = frm_q[idx] ^ byte'(8'h1 << $urandom_range(0, 7));
    end
  endtask

  task automatic send_frame(input int npre);
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    foreach (frm_q[i]) drive(1'b1, frm_q[i]);
    drive(1'b0, 8'h00);
  endtask

  task automatic check_frame(input string tag, input bit corrupt, input bit chk_crc);
    int n, fwd, mism;
    bit lerr, cerr, good;
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    n    = frm_q.size();
    fwd  = ((n < MaxF) ? n : MaxF) - 4;
    if (fwd < 0) fwd = 0;
    lerr = (n < MinF) || (n > MaxF);
    cerr = corrupt;
    good = !lerr && !cerr && chk_crc;
    mism = 0;
    for (int i = 0; i < fwd && i < got_q.size(); i++) if (got_q[i] != frm_q[i]) mism++;
    check({tag, ".nfwd"}, got_q.size(), fwd);
    check({tag, ".data"}, mism, 0);
    check({tag, ".sof"}, sof_cnt, (fwd > 0) ? 1 : 0);
    check({tag, ".sofpos"}, sof_bad, 0);
    check({tag, ".done"}, done_cnt, 1);
    check({tag, ".len"}, last_len, n);
    check({tag, ".lenerr"}, last_lenerr, lerr);
    if (chk_crc) check({tag, ".crcerr"}, last_crc, cerr);
    check({tag, ".good"}, last_good, good);
    if (good) exp_good++;
    else exp_bad++;
    check({tag, ".goodcnt"}, good_cnt, exp_good);
    check({tag, ".badcnt"}, bad_cnt, exp_bad);
    clear_mon();
  endtask

  initial begin
    int n;
    bit c;
    repeat (2) @(posedge clk);
    #1;
    check("rst.data", frm_data, 0);
    check("rst.vld", frm_data_vld, 0);
    check("rst.sof", frm_sof, 0);
    check("rst.done", frm_done, 0);
    check("rst.good", frm_good, 0);
    check("rst.crcerr", frm_crc_err, 0);
    check("rst.lenerr", frm_len_err, 0);
    check("rst.len", frm_len, 0);
    check("rst.goodcnt", good_cnt, 0);
    check("rst.badcnt", bad_cnt, 0);
    rst = 1'b0;
    drive(1'b0, 8'h00);
    clear_mon();

    build_frame(64, 0); send_frame(7); check_frame("good64", 0, 1);
    build_frame(64, 1); send_frame(7); check_frame("crc64", 1, 1);
    build_frame(40, 0); send_frame(7); check_frame("short40", 0, 1);

    // Over-long preamble must be dropped silently.
    for (int i = 0; i < 8; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 70; i++) drive(1'b1, 8'(i));
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    check("pre8.nfwd", got_q.size(), 0);
    check("pre8.done", done_cnt, 0);
    check("pre8.goodcnt", good_cnt, exp_good);
    check("pre8.badcnt", bad_cnt, exp_bad);
    clear_mon();
    build_frame(64, 0); send_frame(7); check_frame("afterpre8", 0, 1);

    // Back-to-back frames with a single idle cycle.
    build_frame(64, 0); send_frame(7);
    build_frame(64, 0); send_frame(7);
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    exp_good += 2;
    check("b2b.done", done_cnt, 2);
    check("b2b.nfwd", got_q.size(), 120);
    check("b2b.good", last_good, 1);
    check("b2b.goodcnt", good_cnt, exp_good);
    clear_mon();

    // Reset mid-payload while dv stays high.
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'h00);
    rst = 1'b1;
    drive(1'b1, 8'h11);
    check("midrst.vld", frm_data_vld, 0);
    check("midrst.done", frm_done, 0);
    check("midrst.goodcnt", good_cnt, 0);
    drive(1'b1, 8'h11);
    check("midrst.badcnt", bad_cnt, 0);
    check("midrst.data", frm_data, 0);
    rst = 1'b0;
    exp_good = 0;
    exp_bad  = 0;
    clear_mon();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h11);
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    check("midrst.nodone", done_cnt, 0);
    check("midrst.nofwd", got_q.size(), 0);
    clear_mon();
    build_frame(64, 0); send_frame(7); check_frame("afterrst", 0, 1);

    // 3-byte frame: nothing forwarded, still reported bad.
    frm_q.delete();
    for (int i = 0; i < 3; i++) frm_q.push_back(byte'($urandom_range(0, 255)));
    send_frame(7);
    check_frame("tiny3", 0, 0);

    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(5, 120);
      c = ($urandom_range(0, 2) == 0);
      build_frame(n, c);
      send_frame($urandom_range(1, 7));
      check_frame("rand", c, 1);
    end

    build_frame(1530, 0); send_frame(7); check_frame("long1530", 0, 1);
    build_frame(1518, 0); send_frame(7); check_frame("max1518", 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/udp_rx_fcs_chk.md
Name: udp_rx_fcs_chk

Overview:
Receive-side GMII frame checker that sits between the PHY GMII receive pins and the UDP receive parser. It strips preamble and SFD, and forwards frame bytes from destination MAC through payload. The 4-byte FCS is withheld via a 4-byte delay line. It computes CRC-32 over the frame and issues a single end-of-frame status (good / CRC error / length error) so downstream logic can commit or discard the buffered frame. It also keeps saturating good/bad frame counters.

Parameters:
MIN_FRAME, 64, minimum legal frame length in bytes (dest MAC through FCS inclusive)
MAX_FRAME, 1518, maximum legal frame length in bytes (dest MAC through FCS inclusive)

Ports:
clk  input  1  GMII receive clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
gmii_rx_dv  input  1  GMII receive data valid
gmii_rxd  input  8  GMII receive data
frm_data  output  8  forwarded frame byte (FCS excluded)
frm_data_vld  output  1  frm_data valid this cycle
frm_sof  output  1  high with the first forwarded byte of a frame
frm_done  output  1  one-cycle pulse: frame ended, status outputs valid
frm_good  output  1  frame CRC correct and length legal; valid with frm_done
frm_crc_err  output  1  CRC residue mismatch; valid with frm_done
frm_len_err  output  1  length < MIN_FRAME or > MAX_FRAME; valid with frm_done
frm_len  output  16  received byte count after SFD incl. FCS, saturating at 16'hFFFF; valid with frm_done
good_cnt  output  16  count of frm_good frames, saturating
bad_cnt  output  16  count of frm_done frames without frm_good, saturating

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high. On reset all outputs are 0, counters are 0, the delay line is cleared, and the FSM goes to IDLE.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE: dv=1 and rxd=0x55 -> PREAMBLE, pre_cnt=1. dv=1 with any other byte -> DROP.
- PREAMBLE: dv=0 -> IDLE, no frm_done. rxd=0xD5 -> DATA, with CRC reg=32'hFFFFFFFF and byte count=0. rxd=0x55 with pre_cnt<7 -> stay, pre_cnt+1. rxd=0x55 with pre_cnt=7 -> DROP. Any other byte -> DROP.
- DATA: each dv=1 byte is shifted into the 4-byte delay line, fed to the CRC and counted. dv=0 -> IDLE and end-of-frame handling.
- DROP: discard bytes until dv=0, then IDLE. No frm_done, counters unchanged.
- CRC: reflected CRC-32, poly 0xEDB88320 (right-shift, LSB first), 8 bits per clock. Covers every byte after SFD including FCS. The frame is CRC-good iff the register equals 32'hDEBB20E3 after the last byte.
- Forwarding, latency 4 bytes: at the edge sampling byte k (k>=4, 0-based after SFD), frm_data<=byte k-4 and frm_data_vld<=1. frm_sof=1 only for k=4. Otherwise frm_data_vld=0. The FCS bytes are therefore never forwarded.
- Forwarding stops after MAX_FRAME-4 bytes. The CRC and count continue, with count saturating at 16'hFFFF.
- End of frame: at the edge sampling dv=0 in DATA, the block registers frm_done=1, frm_len, frm_crc_err, frm_len_err, and frm_good=~crc_err&~len_err. It then increments good_cnt or bad_cnt (saturating at 16'hFFFF).
- Status outputs hold until the next frm_done. frm_done is high for exactly one cycle.
- Frames shorter than 5 bytes forward no data but still produce frm_done with frm_good=0.
- Back-to-back frames: a one-cycle dv gap is sufficient. The cycle carrying the frm_done pulse may coincide with IDLE accepting the next 0x55.
- Reset mid-frame: any outstanding output is abandoned. If dv is still high after release with a non-0x55 byte, the block enters DROP until dv=0.

Test Plan:
- 7x0x55, 0xD5, 60-byte frame + correct FCS (64 total) -> 60 forwarded bytes, sof on the first; frm_done with frm_good=1, frm_len=64, good_cnt=1.
- Same frame with one payload bit flipped -> 60 bytes forwarded; frm_done with frm_crc_err=1, frm_good=0, bad_cnt=1.
- 40-byte frame with valid FCS -> 36 bytes forwarded; frm_len=40, frm_len_err=1, frm_crc_err=0, frm_good=0.
- 8x0x55 then 0xD5 and data -> no frm_data_vld, no frm_done, counters unchanged. A following valid frame after a dv gap is received good.
- Two valid 64-byte frames separated by one dv-low cycle -> two frm_done pulses, both good, good_cnt=2.
- rst asserted for 2 cycles mid-payload, released while dv is high -> all outputs 0 during reset, no frm_done for that frame. The next frame is good.
